// File: rtl/dec_pkg.sv
// Shared encodings for the decode/scan block: request modes and controller states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package dec_pkg;

   // Request mode carried on the 2-bit mode input.
   typedef enum logic [1:0] {
      MODE_DECODE = 2'b00,
      MODE_SCAN   = 2'b01,
      MODE_THERMO = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_t;

   // Controller state: idle accepts requests, scan runs a sweep.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/dec_core.sv
// Index to one-hot converter: bit idx of onehot is set, all others clear.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of idx.
module dec_core #(
   parameter int N = 3
) (
   input  logic [N-1:0]      idx,
   output logic [(2**N)-1:0] onehot
);

   localparam int M = 2**N;

   // A single set bit shifted into place by the index.
   assign onehot = {{(M-1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/dec_scan_nx2n.sv
// N-to-2^N decoder with one-shot DECODE/THERMO codes and a multi-cycle one-hot SCAN sweep.
// Latency: one cycle from acceptance to the first registered code; a sweep lasts 2^N enabled cycles.
// Backpressure: in_ready drops for the whole sweep; en low stalls the sweep without losing position.
module dec_scan_nx2n
   import dec_pkg::*;
#(
   parameter int N = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_sel,
   input  logic [1:0]           mode,
   input  logic                 en,
   output logic [(2**N)-1:0]    out,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 err
);

   localparam int M = 2**N;
   // Sweep length expressed in the N+1 bit counter width (only the top bit set).
   localparam logic [N:0] M_CNT   = {1'b1, {N{1'b0}}};
   localparam logic [N:0] CNT_ONE = {{N{1'b0}}, 1'b1};

   state_t         state, state_nxt;
   logic [M-1:0]   out_nxt;
   logic           ov_nxt, busy_nxt, err_nxt;
   logic [N-1:0]   pos, pos_nxt;
   logic [N:0]     cnt, cnt_nxt;
   logic [N-1:0]   core_idx;
   logic [M-1:0]   oh;
   logic [M-1:0]   therm;

   // During a sweep the converter looks one position ahead (wrapping by N-bit overflow);
   // in idle it converts the incoming select.
   assign core_idx = (state == ST_SCAN) ? pos + 1'b1 : in_sel;

   dec_core #(.N(N)) u_core (
      .idx    (core_idx),
      .onehot (oh)
   );

   // Thermometer: the set bit plus every bit below it.
   assign therm = oh | (oh - 1'b1);

   assign in_ready = (state == ST_IDLE);

   // Next-state and next-output logic for the idle/scan controller.
   always_comb begin
      state_nxt = state;
      out_nxt   = out;
      ov_nxt    = 1'b0;
      busy_nxt  = busy;
      err_nxt   = 1'b0;
      pos_nxt   = pos;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            busy_nxt = 1'b0;
            if (in_valid) begin
               case (mode_t'(mode))
                  MODE_DECODE: begin
                     out_nxt = oh;
                     ov_nxt  = 1'b1;
                  end
                  MODE_THERMO: begin
                     out_nxt = therm;
                     ov_nxt  = 1'b1;
                  end
                  MODE_SCAN: begin
                     out_nxt   = oh;
                     ov_nxt    = 1'b1;
                     busy_nxt  = 1'b1;
                     pos_nxt   = in_sel;
                     cnt_nxt   = CNT_ONE;
                     state_nxt = ST_SCAN;
                  end
                  default: begin
                     out_nxt = '0;
                     err_nxt = 1'b1;
                  end
               endcase
            end
         end
         ST_SCAN: begin
            ov_nxt = 1'b1;
            if (en) begin
               if (cnt == M_CNT) begin
                  // Last position has been shown: leave out holding it.
                  state_nxt = ST_IDLE;
                  busy_nxt  = 1'b0;
                  ov_nxt    = 1'b0;
                  cnt_nxt   = '0;
               end else begin
                  pos_nxt = pos + 1'b1;
                  out_nxt = oh;
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset wins over any acceptance or sweep step.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         out       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         pos       <= '0;
         cnt       <= '0;
      end else begin
         state     <= state_nxt;
         out       <= out_nxt;
         out_valid <= ov_nxt;
         busy      <= busy_nxt;
         err       <= err_nxt;
         pos       <= pos_nxt;
         cnt       <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_dec_scan_nx2n.sv
// Directed bench for dec_scan_nx2n at N = 3 with a queue-based scoreboard.
// Latency: expected values are checked one cycle after each driven step.
// Backpressure: in_ready is part of every compared observation.
module tb_dec_scan_nx2n;

   localparam int N = 3;
   localparam int M = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   in_sel;
   logic [1:0]     mode;
   logic           en;
   logic [M-1:0]   out;
   logic           out_valid;
   logic           busy;
   logic           err;

   typedef struct packed {
      logic [M-1:0] out;
      logic         ov;
      logic         busy;
      logic         err;
      logic         rdy;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   dec_scan_nx2n #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .mode      (mode),
      .en        (en),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy),
      .err       (err)
   );

   task automatic drive(input logic r, input logic v, input logic [N-1:0] s,
                        input logic [1:0] md, input logic e);
      rst      = r;
      in_valid = v;
      in_sel   = s;
      mode     = md;
      en       = e;
   endtask

   task automatic expect_next(input string tag, input logic [M-1:0] o, input logic ov,
                              input logic b, input logic e, input logic r);
      obs_t x;
      x.out  = o;
      x.ov   = ov;
      x.busy = b;
      x.err  = e;
      x.rdy  = r;
      exp_q.push_back(x);
      tag_q.push_back(tag);
   endtask

   task automatic tick();
      obs_t  got;
      obs_t  want;
      string tag;
      @(posedge clk);
      #1;
      got.out  = out;
      got.ov   = out_valid;
      got.busy = busy;
      got.err  = err;
      got.rdy  = in_ready;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: got %b required a queued expectation", got);
      end else begin
         want = exp_q.pop_front();
         tag  = tag_q.pop_front();
         checks++;
         assert (got === want) else begin
            errors++;
            $error("FAIL %s: got out=%b ov=%b busy=%b err=%b rdy=%b required out=%b ov=%b busy=%b err=%b rdy=%b",
                   tag, got.out, got.ov, got.busy, got.err, got.rdy,
                   want.out, want.ov, want.busy, want.err, want.rdy);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [M-1:0] w;

      // Reset state.
      drive(1'b1, 1'b0, 3'd0, 2'b00, 1'b0);
      expect_next("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      expect_next("reset_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();

      // DECODE sweep, back to back; en toggled to show it is ignored.
      for (int i = 0; i < M; i++) begin
         w = 8'h01 << i;
         drive(1'b0, 1'b1, 3'(i), 2'b00, 1'(i & 1));
         expect_next($sformatf("decode_%0d", i), w, 1'b1, 1'b0, 1'b0, 1'b1);
         tick();
      end
      drive(1'b0, 1'b0, 3'd0, 2'b00, 1'b1);
      expect_next("decode_hold", 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();

      // THERMO at 5.
      drive(1'b0, 1'b1, 3'd5, 2'b10, 1'b0);
      expect_next("thermo_5", 8'b0011_1111, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 3'd0, 2'b00, 1'b0);
      expect_next("thermo_hold", 8'b0011_1111, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();

      // SCAN from 6 with wrap; requests during the sweep must be ignored.
      drive(1'b0, 1'b1, 3'd6, 2'b01, 1'b1);
      expect_next("scan6_p0", 8'b0100_0000, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      for (int k = 1; k < M; k++) begin
         w = 8'h01 << ((6 + k) % M);
         drive(1'b0, 1'b1, 3'd3, 2'(k % 4), 1'b1);
         expect_next($sformatf("scan6_p%0d", k), w, 1'b1, 1'b1, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 1'b1, 3'd3, 2'b00, 1'b1);
      expect_next("scan6_end", 8'b0010_0000, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();

      // SCAN from 0 with a 3-cycle stall at position 2.
      drive(1'b0, 1'b1, 3'd0, 2'b01, 1'b1);
      expect_next("scan0_p0", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 3'd0, 2'b00, 1'b1);
      expect_next("scan0_p1", 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_next("scan0_p2", 8'h04, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 3'd0, 2'b00, 1'b0);
         expect_next($sformatf("scan0_stall%0d", k), 8'h04, 1'b1, 1'b1, 1'b0, 1'b0);
         tick();
      end
      for (int k = 3; k < M; k++) begin
         w = 8'h01 << k;
         drive(1'b0, 1'b0, 3'd0, 2'b00, 1'b1);
         expect_next($sformatf("scan0_p%0d", k), w, 1'b1, 1'b1, 1'b0, 1'b0);
         tick();
      end
      expect_next("scan0_end", 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();

      // Reset in the middle of a sweep (at position showing bit 4).
      drive(1'b0, 1'b1, 3'd0, 2'b01, 1'b1);
      expect_next("scanr_p0", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      for (int k = 1; k <= 4; k++) begin
         w = 8'h01 << k;
         drive(1'b0, 1'b0, 3'd0, 2'b00, 1'b1);
         expect_next($sformatf("scanr_p%0d", k), w, 1'b1, 1'b1, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 1'b1, 3'd2, 2'b01, 1'b1);
      expect_next("scan_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b1, 3'd1, 2'b00, 1'b1);
      expect_next("post_rst_decode1", 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 3'd0, 2'b00, 1'b1);
      expect_next("post_rst_no_resume", 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();

      // Reserved mode: one-cycle err, cleared output.
      drive(1'b0, 1'b1, 3'd5, 2'b11, 1'b0);
      expect_next("rsvd_err", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      drive(1'b0, 1'b0, 3'd0, 2'b00, 1'b0);
      expect_next("rsvd_err_clear", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();

      // Reset overrides a simultaneous DECODE acceptance.
      drive(1'b0, 1'b1, 3'd7, 2'b10, 1'b0);
      expect_next("thermo_7", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 1'b1, 3'd7, 2'b00, 1'b0);
      expect_next("rst_vs_accept", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
